ysyx_040066_regfile_sb: RTL and testbench
=========================================

// Module: ysyx_040066_regfile_sb
// PURPOSE
//  Parametrised integer register file with operand bypass and a long-latency scoreboard.
//  Sits at the decode/issue boundary and replaces the fixed 2-read, EX/M/WB-forwarding register file.
//  Adds NRD read ports, NBYP generic bypass sources, and per-register busy/owner tracking
//  for NLONG multi-cycle units (mul/div), which get their own write ports and kill support.
// PARAMETERS
//  XLEN   64  data width
//  NREG   32  architectural registers; x0 is hard zero; AW=$clog2(NREG)
//  NRD    2   read ports
//  NBYP   2   bypass sources; index 0 = youngest stage (EX), then M, ...
//  NLONG  2   long-latency units (0=mul, 1=div); OW=max(1,$clog2(NLONG))
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst_n        in   1            asynchronous reset, active low
//  wb_wen       in   1            in-order writeback write enable
//  wb_rd        in   AW           writeback destination
//  wb_data      in   XLEN         writeback data
//  byp_wen      in   NBYP         bypass stage i will write byp_rd[i]
//  byp_valid    in   NBYP         bypass stage i data already computed
//  byp_rd       in   NBYP*AW      bypass destinations, slice i = [i*AW +: AW]
//  byp_data     in   NBYP*XLEN    bypass data
//  lu_issue     in   NLONG        unit u accepted an op this cycle
//  lu_issue_rd  in   NLONG*AW     destination of issued op
//  lu_wen       in   NLONG        unit u completes and writes this cycle
//  lu_rd        in   NLONG*AW     completion destination
//  lu_data      in   NLONG*XLEN   completion data
//  lu_kill      in   NLONG        unit u op flushed; release its reservations
//  rs           in   NRD*AW       read addresses
//  rs_data      out  NRD*XLEN     read data
//  rs_valid     out  NRD          1 = rs_data usable now; 0 = issue must stall
//  busy_vec     out  NREG         per-register pending long-latency write (bit 0 always 0)
// BEHAVIOUR
//  State: rf[NREG][XLEN], busy[NREG], owner[NREG][OW]. rst_n low: all cleared to 0 asynchronously;
//   outputs then: busy_vec=0, rs_data=0 for every rs, rs_valid=all 1. Reset mid-op drops all reservations.
//  Read (combinational, zero latency), per port p, first match wins:
//   1 rs==0                              -> data 0, valid 1
//   2 byp_wen[i]&&byp_rd[i]==rs, lowest i -> byp_data[i], valid byp_valid[i]
//   3 lu_wen[u]&&lu_rd[u]==rs, lowest u   -> lu_data[u], valid 1
//   4 wb_wen&&wb_rd==rs                  -> wb_data, valid 1
//   5 busy[rs]                           -> rf[rs], valid 0
//   6 otherwise                          -> rf[rs], valid 1
//  Writes (next edge): wb and every lu_wen write rf; writes to x0 dropped.
//   Same register, same cycle: lowest-index lu wins over higher lu, any lu wins over wb.
//  Scoreboard (next edge), applied in order kill -> completion -> issue, so later step wins:
//   kill[u]: clear busy[r] for every r with busy[r]&&owner[r]==u.
//   lu_wen[u]: clear busy[lu_rd] only if owner[lu_rd]==u (stale completion leaves newer owner busy).
//   lu_issue[u], rd!=0: busy[rd]<=1, owner[rd]<=u. Issue of x0 ignored.
//   Simultaneous completion and re-issue of same rd: register written AND stays busy with new owner.
//  wb_wen to a busy register writes rf, busy unchanged (issue logic must prevent WAW; sim assertion flags it).
//  lu_wen with kill[u] same cycle: write still performed (unit guarantees it never completes a killed op).
//  No internal pipelining: busy_vec reflects registered state only (issue this cycle visible next cycle).
// TESTING
//  T1 reset: rst_n=0 mid-traffic -> busy_vec=0, rs=5 reads 0 valid 1; after release, x0 write of 0xFF ignored.
//  T2 priority: byp0,byp1,wb all target x7 with 0x11/0x22/0x33, byp_valid=2'b10 -> rs=7 gives 0x11 valid 0;
//     drop byp0 -> 0x22 valid 1.
//  T3 scoreboard: issue mul rd=x9 -> next cycle busy_vec[9]=1, rs=9 valid 0; lu_wen[0] x9=0xABCD ->
//     same cycle rs=9 0xABCD valid 1; next cycle busy_vec[9]=0, rf=0xABCD.
//  T4 owner/stale: mul owns x3, div issues x3 (owner=1); mul completes x3 -> rf updated, busy[3] stays 1;
//     div completes -> busy[3]=0.
//  T5 kill: div owns x4,x12, mul owns x5; lu_kill[1] -> busy_vec[4]=busy_vec[12]=0, busy_vec[5]=1.
//  T6 collision: lu_wen[0],lu_wen[1],wb all write x20 (1,2,3) -> rf[20]=1; repeat for NRD=4, NBYP=3, NLONG=3 build.

Source files
------------

// File: rtl/ysyx_040066_regfile_sb.sv
// Integer register file with generic operand bypass and a long-latency scoreboard
// that tracks, per register, which multi-cycle unit still owes it a result.
module ysyx_040066_regfile_sb #(
  parameter  int XLEN  = 64,
  parameter  int NREG  = 32,
  parameter  int NRD   = 2,
  parameter  int NBYP  = 2,
  parameter  int NLONG = 2,
  localparam int AW    = $clog2(NREG),
  localparam int OW    = (NLONG > 1) ? $clog2(NLONG) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_wen,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [NBYP-1:0]       byp_wen,
  input  logic [NBYP-1:0]       byp_valid,
  input  logic [NBYP*AW-1:0]    byp_rd,
  input  logic [NBYP*XLEN-1:0]  byp_data,
  input  logic [NLONG-1:0]      lu_issue,
  input  logic [NLONG*AW-1:0]   lu_issue_rd,
  input  logic [NLONG-1:0]      lu_wen,
  input  logic [NLONG*AW-1:0]   lu_rd,
  input  logic [NLONG*XLEN-1:0] lu_data,
  input  logic [NLONG-1:0]      lu_kill,
  input  logic [NRD*AW-1:0]     rs,
  output logic [NRD*XLEN-1:0]   rs_data,
  output logic [NRD-1:0]        rs_valid,
  output logic [NREG-1:0]       busy_vec
);

  logic [NREG-1:0][XLEN-1:0] r_rf;
  logic [NREG-1:0]           r_busy;
  logic [NREG-1:0][OW-1:0]   r_owner;

  logic [NREG-1:0][XLEN-1:0] w_rf_nxt;
  logic [NREG-1:0]           w_busy_nxt;
  logic [NREG-1:0][OW-1:0]   w_owner_nxt;
  logic [NRD-1:0][XLEN-1:0]  w_rdata;
  logic [NRD-1:0]            w_rvalid;

  // Sources are layered lowest priority first so each later match overrides;
  // descending index loops make the lowest-index source the final winner.
  always_comb begin
    w_rdata  = '0;
    w_rvalid = '0;
    for (int p = 0; p < NRD; p++) begin
      w_rdata[p]  = r_rf[rs[p*AW +: AW]];
      w_rvalid[p] = !r_busy[rs[p*AW +: AW]];
      if (wb_wen && wb_rd == rs[p*AW +: AW]) begin
        w_rdata[p]  = wb_data;
        w_rvalid[p] = 1'b1;
      end
      for (int u = NLONG - 1; u >= 0; u--) begin
        if (lu_wen[u] && lu_rd[u*AW +: AW] == rs[p*AW +: AW]) begin
          w_rdata[p]  = lu_data[u*XLEN +: XLEN];
          w_rvalid[p] = 1'b1;
        end
      end
      for (int i = NBYP - 1; i >= 0; i--) begin
        if (byp_wen[i] && byp_rd[i*AW +: AW] == rs[p*AW +: AW]) begin
          w_rdata[p]  = byp_data[i*XLEN +: XLEN];
          w_rvalid[p] = byp_valid[i];
        end
      end
      if (rs[p*AW +: AW] == '0) begin
        w_rdata[p]  = '0;
        w_rvalid[p] = 1'b1;
      end
    end
  end

  assign rs_data  = w_rdata;
  assign rs_valid = w_rvalid;
  assign busy_vec = r_busy;

  always_comb begin
    w_rf_nxt = r_rf;
    if (wb_wen && wb_rd != '0)
      w_rf_nxt[wb_rd] = wb_data;
    for (int u = NLONG - 1; u >= 0; u--) begin
      if (lu_wen[u] && lu_rd[u*AW +: AW] != '0)
        w_rf_nxt[lu_rd[u*AW +: AW]] = lu_data[u*XLEN +: XLEN];
    end
  end

  // Kill, then completion, then issue: a completion only releases a register
  // its own unit still owns, and a same-cycle re-issue keeps it reserved.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_owner_nxt = r_owner;
    for (int u = 0; u < NLONG; u++) begin
      for (int r = 0; r < NREG; r++) begin
        if (lu_kill[u] && r_busy[r] && r_owner[r] == OW'(u))
          w_busy_nxt[r] = 1'b0;
      end
    end
    for (int u = 0; u < NLONG; u++) begin
      if (lu_wen[u] && r_owner[lu_rd[u*AW +: AW]] == OW'(u))
        w_busy_nxt[lu_rd[u*AW +: AW]] = 1'b0;
    end
    for (int u = 0; u < NLONG; u++) begin
      if (lu_issue[u] && lu_issue_rd[u*AW +: AW] != '0) begin
        w_busy_nxt[lu_issue_rd[u*AW +: AW]]  = 1'b1;
        w_owner_nxt[lu_issue_rd[u*AW +: AW]] = OW'(u);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf    <= '0;
      r_busy  <= '0;
      r_owner <= '0;
    end else begin
      r_rf    <= w_rf_nxt;
      r_busy  <= w_busy_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // In-order writeback into a register still owed by a long unit is a WAW hazard.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_wen && wb_rd != '0 && r_busy[wb_rd]));

endmodule

// File: tb/tb_ysyx_040066_regfile_sb.sv
// Bench for ysyx_040066_regfile_sb: directed vectors with literal checks, plus a
// behavioural model compared against the default build on every falling edge.
module tb_ysyx_040066_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NBYP = 2;
  localparam int NLONG = 2;
  localparam int NRD2 = 4;
  localparam int NBYP2 = 3;
  localparam int NLONG2 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                  wb_wen;
  logic [AW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [NBYP-1:0]       byp_wen, byp_valid;
  logic [NBYP*AW-1:0]    byp_rd;
  logic [NBYP*XLEN-1:0]  byp_data;
  logic [NLONG-1:0]      lu_issue, lu_wen, lu_kill;
  logic [NLONG*AW-1:0]   lu_issue_rd, lu_rd;
  logic [NLONG*XLEN-1:0] lu_data;
  logic [NRD*AW-1:0]     rs;
  logic [NRD*XLEN-1:0]   rs_data;
  logic [NRD-1:0]        rs_valid;
  logic [NREG-1:0]       busy_vec;

  logic                   wb_wen2;
  logic [AW-1:0]          wb_rd2;
  logic [XLEN-1:0]        wb_data2;
  logic [NBYP2-1:0]       byp_wen2, byp_valid2;
  logic [NBYP2*AW-1:0]    byp_rd2;
  logic [NBYP2*XLEN-1:0]  byp_data2;
  logic [NLONG2-1:0]      lu_issue2, lu_wen2, lu_kill2;
  logic [NLONG2*AW-1:0]   lu_issue_rd2, lu_rd2;
  logic [NLONG2*XLEN-1:0] lu_data2;
  logic [NRD2*AW-1:0]     rs2;
  logic [NRD2*XLEN-1:0]   rs_data2;
  logic [NRD2-1:0]        rs_valid2;
  logic [NREG-1:0]        busy_vec2;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  ysyx_040066_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .byp_wen(byp_wen), .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .lu_wen(lu_wen), .lu_rd(lu_rd),
    .lu_data(lu_data), .lu_kill(lu_kill),
    .rs(rs), .rs_data(rs_data), .rs_valid(rs_valid), .busy_vec(busy_vec)
  );

  ysyx_040066_regfile_sb #(.NRD(NRD2), .NBYP(NBYP2), .NLONG(NLONG2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .wb_wen(wb_wen2), .wb_rd(wb_rd2), .wb_data(wb_data2),
    .byp_wen(byp_wen2), .byp_valid(byp_valid2), .byp_rd(byp_rd2), .byp_data(byp_data2),
    .lu_issue(lu_issue2), .lu_issue_rd(lu_issue_rd2), .lu_wen(lu_wen2), .lu_rd(lu_rd2),
    .lu_data(lu_data2), .lu_kill(lu_kill2),
    .rs(rs2), .rs_data(rs_data2), .rs_valid(rs_valid2), .busy_vec(busy_vec2)
  );

  // Architectural model of the default build.
  logic [XLEN-1:0] mRf[NREG];
  bit              mBusy[NREG];
  int              mOwner[NREG];

  initial begin
    for (int r = 0; r < NREG; r++) begin
      mRf[r] = '0;
      mBusy[r] = 1'b0;
      mOwner[r] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mRf[r] = '0;
        mBusy[r] = 1'b0;
        mOwner[r] = 0;
      end
    end else begin
      bit taken[NREG];
      for (int r = 0; r < NREG; r++) taken[r] = 1'b0;
      for (int u = 0; u < NLONG; u++) begin
        if (lu_wen[u] && lu_rd[u*AW +: AW] != 0 && !taken[lu_rd[u*AW +: AW]]) begin
          mRf[lu_rd[u*AW +: AW]] = lu_data[u*XLEN +: XLEN];
          taken[lu_rd[u*AW +: AW]] = 1'b1;
        end
      end
      if (wb_wen && wb_rd != 0 && !taken[wb_rd]) mRf[wb_rd] = wb_data;
      for (int u = 0; u < NLONG; u++)
        if (lu_kill[u])
          for (int r = 0; r < NREG; r++)
            if (mBusy[r] && mOwner[r] == u) mBusy[r] = 1'b0;
      for (int u = 0; u < NLONG; u++)
        if (lu_wen[u] && mOwner[lu_rd[u*AW +: AW]] == u) mBusy[lu_rd[u*AW +: AW]] = 1'b0;
      for (int u = 0; u < NLONG; u++)
        if (lu_issue[u] && lu_issue_rd[u*AW +: AW] != 0) begin
          mBusy[lu_issue_rd[u*AW +: AW]] = 1'b1;
          mOwner[lu_issue_rd[u*AW +: AW]] = u;
        end
    end
  end

  function automatic logic [XLEN:0] modelRead(input logic [AW-1:0] a);
    if (a == 0) return {1'b1, {XLEN{1'b0}}};
    for (int i = 0; i < NBYP; i++)
      if (byp_wen[i] && byp_rd[i*AW +: AW] == a) return {byp_valid[i], byp_data[i*XLEN +: XLEN]};
    for (int u = 0; u < NLONG; u++)
      if (lu_wen[u] && lu_rd[u*AW +: AW] == a) return {1'b1, lu_data[u*XLEN +: XLEN]};
    if (wb_wen && wb_rd == a) return {1'b1, wb_data};
    return {!mBusy[a], mRf[a]};
  endfunction

  function automatic logic [NREG-1:0] modelBusyVec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = mBusy[r];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      logic [XLEN:0] m;
      checkOutput("cmp_busy_vec", XLEN'(busy_vec), XLEN'(modelBusyVec()));
      for (int p = 0; p < NRD; p++) begin
        m = modelRead(rs[p*AW +: AW]);
        checkOutput("cmp_rs_data", rs_data[p*XLEN +: XLEN], m[XLEN-1:0]);
        checkOutput("cmp_rs_valid", XLEN'(rs_valid[p]), XLEN'(m[XLEN]));
      end
    end
  end

  task automatic clearInputs();
    wb_wen = 0; wb_rd = '0; wb_data = '0;
    byp_wen = '0; byp_valid = '0; byp_rd = '0; byp_data = '0;
    lu_issue = '0; lu_issue_rd = '0; lu_wen = '0; lu_rd = '0; lu_data = '0; lu_kill = '0;
    rs = '0;
    wb_wen2 = 0; wb_rd2 = '0; wb_data2 = '0;
    byp_wen2 = '0; byp_valid2 = '0; byp_rd2 = '0; byp_data2 = '0;
    lu_issue2 = '0; lu_issue_rd2 = '0; lu_wen2 = '0; lu_rd2 = '0; lu_data2 = '0; lu_kill2 = '0;
    rs2 = '0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setRead(input int p, input logic [AW-1:0] a);
    rs[p*AW +: AW] = a;
  endtask

  task automatic setByp(input int i, input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    byp_wen[i] = 1'b1; byp_valid[i] = v; byp_rd[i*AW +: AW] = rd; byp_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic setIssue(input int u, input logic [AW-1:0] rd);
    lu_issue[u] = 1'b1; lu_issue_rd[u*AW +: AW] = rd;
  endtask

  task automatic setComplete(input int u, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    lu_wen[u] = 1'b1; lu_rd[u*AW +: AW] = rd; lu_data[u*XLEN +: XLEN] = d;
  endtask

  task automatic setWb(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_wen = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic checkRead(input string name, input int p, input logic [XLEN-1:0] d, input logic v);
    checkOutput({name, "_data"}, rs_data[p*XLEN +: XLEN], d);
    checkOutput({name, "_valid"}, XLEN'(rs_valid[p]), XLEN'(v));
  endtask

  task automatic checkBusy(input string name, input int r, input logic v);
    checkOutput(name, XLEN'(busy_vec[r]), XLEN'(v));
  endtask

  initial begin
    clearInputs();
    #2 rst_n = 1'b0;
    checkOn = 1'b1;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    setRead(0, 5);
    #2 checkOutput("reset_busy_vec", XLEN'(busy_vec), '0);
    checkRead("reset_rs5", 0, '0, 1'b1);

    // T1: reset asserted while long ops are in flight
    applyStimulus();
    clearInputs();
    setIssue(0, 5); setIssue(1, 6);
    applyStimulus();
    clearInputs();
    #1 checkOutput("t1_busy_before", XLEN'(busy_vec), XLEN'(32'h0000_0060));
    setIssue(0, 8); setRead(0, 5);
    rst_n = 1'b0;
    #1 checkOutput("t1_busy_in_reset", XLEN'(busy_vec), '0);
    checkRead("t1_rs5_in_reset", 0, '0, 1'b1);
    clearInputs();
    rst_n = 1'b1;
    applyStimulus();
    setWb(0, 64'hFF);
    applyStimulus();
    clearInputs();
    setRead(0, 0);
    #2 checkRead("t1_x0", 0, '0, 1'b1);

    // T2: read-source priority
    applyStimulus();
    setRead(0, 7); setRead(1, 7);
    setByp(0, 1'b0, 7, 64'h11); setByp(1, 1'b1, 7, 64'h22); setWb(7, 64'h33);
    #2 checkRead("t2_byp0", 0, 64'h11, 1'b0);
    byp_wen[0] = 1'b0;
    #1 checkRead("t2_byp1", 1, 64'h22, 1'b1);
    applyStimulus();
    clearInputs();
    setRead(0, 7);
    #2 checkRead("t2_rf7", 0, 64'h33, 1'b1);

    // T3: issue, busy read, completion forwarding
    applyStimulus();
    clearInputs();
    setIssue(0, 9);
    applyStimulus();
    clearInputs();
    setRead(0, 9);
    #2 checkBusy("t3_busy9_set", 9, 1'b1);
    checkRead("t3_rs9_busy", 0, '0, 1'b0);
    setComplete(0, 9, 64'hABCD);
    #1 checkRead("t3_rs9_fwd", 0, 64'hABCD, 1'b1);
    applyStimulus();
    clearInputs();
    setRead(1, 9);
    #2 checkBusy("t3_busy9_clr", 9, 1'b0);
    checkRead("t3_rf9", 1, 64'hABCD, 1'b1);

    // T4: stale completion from a superseded owner
    applyStimulus();
    clearInputs();
    setIssue(0, 3);
    applyStimulus();
    clearInputs();
    setIssue(1, 3);
    applyStimulus();
    clearInputs();
    setComplete(0, 3, 64'h333);
    applyStimulus();
    clearInputs();
    setRead(0, 3);
    #2 checkBusy("t4_busy3_stale", 3, 1'b1);
    checkRead("t4_rs3_stale", 0, 64'h333, 1'b0);
    setComplete(1, 3, 64'h444);
    applyStimulus();
    clearInputs();
    setRead(0, 3);
    #2 checkBusy("t4_busy3_clr", 3, 1'b0);
    checkRead("t4_rf3", 0, 64'h444, 1'b1);

    // completion and re-issue of the same register in one cycle
    applyStimulus();
    clearInputs();
    setIssue(0, 9);
    applyStimulus();
    clearInputs();
    setComplete(0, 9, 64'h99); setIssue(1, 9);
    applyStimulus();
    clearInputs();
    setRead(0, 9);
    #2 checkBusy("t4_reissue_busy", 9, 1'b1);
    checkRead("t4_reissue_rs9", 0, 64'h99, 1'b0);
    setComplete(1, 9, 64'h9A);
    applyStimulus();
    clearInputs();
    #2 checkBusy("t4_reissue_clr", 9, 1'b0);

    // T5: kill releases only the killed unit's reservations
    applyStimulus();
    clearInputs();
    setIssue(1, 4); setIssue(0, 5);
    applyStimulus();
    clearInputs();
    setIssue(1, 12);
    applyStimulus();
    clearInputs();
    #2 checkOutput("t5_busy_pre", XLEN'(busy_vec), XLEN'(32'h0000_1030));
    lu_kill[1] = 1'b1;
    applyStimulus();
    clearInputs();
    #2 checkBusy("t5_busy4", 4, 1'b0);
    checkBusy("t5_busy12", 12, 1'b0);
    checkBusy("t5_busy5", 5, 1'b1);
    setComplete(0, 5, 64'h55);
    applyStimulus();
    clearInputs();

    // T6: write collision on one register
    setComplete(0, 20, 64'd1); setComplete(1, 20, 64'd2); setWb(20, 64'd3);
    applyStimulus();
    clearInputs();
    setRead(1, 20);
    #2 checkRead("t6_rf20", 1, 64'd1, 1'b1);
    setComplete(1, 21, 64'd2); setWb(21, 64'd3);
    applyStimulus();
    clearInputs();
    setRead(0, 21);
    #2 checkRead("t6_rf21", 0, 64'd2, 1'b1);

    // T6 on the wider build
    applyStimulus();
    clearInputs();
    lu_wen2 = 3'b111;
    lu_rd2 = {5'd20, 5'd20, 5'd20};
    lu_data2 = {64'd5, 64'd2, 64'd1};
    wb_wen2 = 1'b1; wb_rd2 = 5'd20; wb_data2 = 64'd3;
    applyStimulus();
    clearInputs();
    rs2[3*AW +: AW] = 5'd20;
    #2 checkOutput("t6w_rf20", rs_data2[3*XLEN +: XLEN], 64'd1);
    checkOutput("t6w_rf20_valid", XLEN'(rs_valid2[3]), 64'd1);
    lu_wen2 = 3'b110;
    lu_rd2 = {5'd22, 5'd22, 5'd0};
    lu_data2 = {64'd5, 64'd2, 64'd0};
    wb_wen2 = 1'b1; wb_rd2 = 5'd22; wb_data2 = 64'd3;
    applyStimulus();
    clearInputs();
    rs2[2*AW +: AW] = 5'd22;
    byp_wen2 = 3'b100; byp_valid2 = 3'b100;
    byp_rd2 = {5'd9, 5'd0, 5'd0};
    byp_data2 = {64'h77, 64'h0, 64'h0};
    rs2[1*AW +: AW] = 5'd9;
    #2 checkOutput("t6w_rf22", rs_data2[2*XLEN +: XLEN], 64'd2);
    checkOutput("t6w_byp2", rs_data2[1*XLEN +: XLEN], 64'h77);
    checkOutput("t6w_busy_none", XLEN'(busy_vec2), '0);
    applyStimulus();
    clearInputs();
    lu_issue2 = 3'b100; lu_issue_rd2 = {5'd11, 5'd0, 5'd0};
    applyStimulus();
    clearInputs();
    #2 checkOutput("t6w_busy11", XLEN'(busy_vec2), XLEN'(32'h0000_0800));
    lu_kill2 = 3'b100;
    applyStimulus();
    clearInputs();
    #2 checkOutput("t6w_busy11_killed", XLEN'(busy_vec2), '0);

    applyStimulus();
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
